// File: rtl/voice_increment_scheduler.sv
// Multi-voice sample-address scheduler: one voice advanced per cycle on each sample_clk frame.
// Build option VOICE_LOOP_EN: a voice whose note_gate is held restarts instead of retiring.
//
// state      | meaning
// WAIT_START | after reset, waiting for init; sample_clk edges ignored
// IDLE       | waiting for a sample_clk rising edge
// LOAD       | pending voices restart at address 0
// SCAN       | voice idx advanced or retired this cycle
// FRAME      | end-of-frame pulse
module voice_increment_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 16,
    parameter int LEN_W      = 16,
    localparam int IDX_W     = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         init,
    input  logic                         sample_clk,
    input  logic [NUM_VOICES-1:0]        note_on,
    input  logic [NUM_VOICES*LEN_W-1:0]  note_len,
    input  logic [NUM_VOICES*ADDR_W-1:0] note_step,
    input  logic [NUM_VOICES-1:0]        note_gate,
    output logic [NUM_VOICES*ADDR_W-1:0] voice_addr,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         incr,
    output logic [IDX_W-1:0]             incr_voice,
    output logic [NUM_VOICES-1:0]        note_done,
    output logic                         frame_done,
    output logic                         overrun
);

    typedef enum logic [2:0] {WAIT_START, IDLE, LOAD, SCAN, FRAME} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             sclk_q;
    logic             sclk_edge;

    logic [ADDR_W-1:0] addr_q     [NUM_VOICES];
    logic [ADDR_W-1:0] step_q     [NUM_VOICES];
    logic [ADDR_W-1:0] stage_step [NUM_VOICES];
    logic [LEN_W-1:0]  len_q      [NUM_VOICES];
    logic [LEN_W-1:0]  rem_q      [NUM_VOICES];
    logic [LEN_W-1:0]  stage_len  [NUM_VOICES];
    logic [NUM_VOICES-1:0] active_q;
    logic [NUM_VOICES-1:0] pending;
    logic [NUM_VOICES-1:0] loaded;

    logic scan_live;
    logic at_end;
    logic do_incr;
    logic do_loop;
    logic do_retire;

    always_ff @(posedge Clk) sclk_q <= sample_clk;

    assign sclk_edge = sample_clk & ~sclk_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= WAIT_START;
            idx     <= '0;
            overrun <= 1'b0;
        end else begin
            if (init)
                overrun <= 1'b0;
            // Edges that land mid-frame are dropped, never queued.
            if (sclk_edge && (state == LOAD || state == SCAN || state == FRAME))
                overrun <= 1'b1;
            case (state)
                WAIT_START: if (init) state <= IDLE;
                IDLE:       if (sclk_edge) state <= LOAD;
                LOAD: begin
                    state <= SCAN;
                    idx   <= '0;
                end
                SCAN: begin
                    if (idx == LAST_IDX)
                        state <= FRAME;
                    else
                        idx <= idx + IDX_W'(1);
                end
                FRAME:      state <= IDLE;
                default:    state <= WAIT_START;
            endcase
        end
    end

    // rem_q counts the samples still to be advanced; zero means end of length.
    assign scan_live = (state == SCAN) && !Reset && active_q[idx] && !loaded[idx];
    assign at_end    = scan_live && (rem_q[idx] == '0);
    assign do_incr   = scan_live && (rem_q[idx] != '0);
`ifdef VOICE_LOOP_EN
    assign do_loop   = at_end && note_gate[idx];
`else
    logic unused_gate;
    assign unused_gate = ^note_gate;
    assign do_loop     = 1'b0;
`endif
    assign do_retire = at_end && !do_loop;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                addr_q[i]     <= '0;
                step_q[i]     <= '0;
                stage_step[i] <= '0;
                len_q[i]      <= '0;
                rem_q[i]      <= '0;
                stage_len[i]  <= '0;
            end
            active_q <= '0;
            pending  <= '0;
            loaded   <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (note_on[i]) begin
                    stage_len[i]  <= (note_len[i*LEN_W +: LEN_W] == '0) ? LEN_W'(1)
                                                                        : note_len[i*LEN_W +: LEN_W];
                    stage_step[i] <= note_step[i*ADDR_W +: ADDR_W];
                end
            end
            if (state == LOAD) begin
                pending <= note_on;
                loaded  <= pending;
                for (int i = 0; i < NUM_VOICES; i++) begin
                    if (pending[i]) begin
                        addr_q[i]   <= '0;
                        len_q[i]    <= stage_len[i];
                        step_q[i]   <= stage_step[i];
                        rem_q[i]    <= stage_len[i] - LEN_W'(1);
                        active_q[i] <= 1'b1;
                    end
                end
            end else begin
                pending <= pending | note_on;
            end
            if (do_incr) begin
                addr_q[idx] <= addr_q[idx] + step_q[idx];
                rem_q[idx]  <= rem_q[idx] - LEN_W'(1);
            end
            if (do_loop) begin
                addr_q[idx] <= '0;
                rem_q[idx]  <= len_q[idx] - LEN_W'(1);
            end
            if (do_retire)
                active_q[idx] <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_addr
        assign voice_addr[g*ADDR_W +: ADDR_W] = addr_q[g];
    end

    assign voice_active = active_q;
    assign incr         = do_incr;
    assign incr_voice   = do_incr ? idx : '0;
    assign frame_done   = (state == FRAME) && !Reset;

    always_comb begin
        note_done = '0;
        if (do_retire)
            note_done[idx] = 1'b1;
    end

endmodule

// File: tb/tb_voice_increment_scheduler.sv
// Bench for voice_increment_scheduler: directed scenarios plus random notes, checked against a
// frame-level reference model; honours VOICE_LOOP_EN when the build defines it.
module tb_voice_increment_scheduler;
    localparam int NV = 4;
    localparam int AW = 16;
    localparam int LW = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             init;
    logic             sample_clk;
    logic [NV-1:0]    note_on;
    logic [NV*LW-1:0] note_len;
    logic [NV*AW-1:0] note_step;
    logic [NV-1:0]    note_gate;
    logic [NV*AW-1:0] voice_addr;
    logic [NV-1:0]    voice_active;
    logic             incr;
    logic [1:0]       incr_voice;
    logic [NV-1:0]    note_done;
    logic             frame_done;
    logic             overrun;

    voice_increment_scheduler #(.NUM_VOICES(NV), .ADDR_W(AW), .LEN_W(LW)) dut (
        .Clk(Clk), .Reset(Reset), .init(init), .sample_clk(sample_clk),
        .note_on(note_on), .note_len(note_len), .note_step(note_step), .note_gate(note_gate),
        .voice_addr(voice_addr), .voice_active(voice_active), .incr(incr),
        .incr_voice(incr_voice), .note_done(note_done), .frame_done(frame_done),
        .overrun(overrun)
    );

    always #5 Clk = ~Clk;

    int passed = 0;
    int total  = 0;

    // Reference model: per-voice note state in terms of samples played so far.
    bit m_pend  [NV];
    int m_slen  [NV];
    int m_sstep [NV];
    int m_addr  [NV];
    bit m_act   [NV];
    int m_len   [NV];
    int m_step  [NV];
    int m_played[NV];
    bit m_over;
    bit e_incr  [NV];
    bit e_done  [NV];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_pend[i] = 0; m_slen[i] = 0; m_sstep[i] = 0; m_addr[i] = 0;
            m_act[i] = 0; m_len[i] = 0; m_step[i] = 0; m_played[i] = 0;
        end
        m_over = 0;
    endtask

    task automatic model_stage(input int v, input int len, input int step);
        m_pend[v]  = 1;
        m_slen[v]  = (len == 0) ? 1 : len;
        m_sstep[v] = step & 'hFFFF;
    endtask

    task automatic model_frame();
        bit fresh[NV];
        for (int i = 0; i < NV; i++) begin
            fresh[i] = m_pend[i];
            if (m_pend[i]) begin
                m_pend[i] = 0; m_addr[i] = 0; m_played[i] = 1; m_act[i] = 1;
                m_len[i] = m_slen[i]; m_step[i] = m_sstep[i];
            end
        end
        for (int i = 0; i < NV; i++) begin
            e_incr[i] = 0;
            e_done[i] = 0;
            if (!fresh[i] && m_act[i]) begin
                if (m_played[i] < m_len[i]) begin
                    m_addr[i] = (m_addr[i] + m_step[i]) & 'hFFFF;
                    m_played[i]++;
                    e_incr[i] = 1;
                end
`ifdef VOICE_LOOP_EN
                else if (note_gate[i]) begin
                    m_addr[i] = 0;
                    m_played[i] = 1;
                end
`endif
                else begin
                    m_act[i] = 0;
                    e_done[i] = 1;
                end
            end
        end
    endtask

    task automatic stage(input int v, input int len, input int step);
        note_on[v] = 1'b1;
        note_len[v*LW +: LW]  = len[LW-1:0];
        note_step[v*AW +: AW] = step[AW-1:0];
        model_stage(v, len, step);
        tick();
        note_on = '0;
    endtask

    task automatic check_voices(input string tag);
        logic [NV-1:0] act;
        for (int i = 0; i < NV; i++) begin
            act[i] = m_act[i];
            chk($sformatf("%s_addr%0d", tag, i), voice_addr[i*AW +: AW], m_addr[i]);
        end
        chk({tag, "_active"}, voice_active, act);
        chk({tag, "_overrun"}, overrun, m_over);
    endtask

    task automatic idle_check(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            chk("idle_frame_done", frame_done, 0);
            chk("idle_incr", incr, 0);
            chk("idle_overrun", overrun, m_over);
            tick();
        end
    endtask

    // One sample frame; optionally a note_on in the LOAD cycle and a second edge during SCAN.
    task automatic do_frame(input int lo_v, input int lo_len, input int lo_step, input bit extra_edge);
        logic [NV-1:0] dexp;
        sample_clk = 1'b1;
        model_frame();
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) begin
                sample_clk = 1'b0;
                if (lo_v >= 0) begin
                    note_on[lo_v] = 1'b1;
                    note_len[lo_v*LW +: LW]  = lo_len[LW-1:0];
                    note_step[lo_v*AW +: AW] = lo_step[AW-1:0];
                    model_stage(lo_v, lo_len, lo_step);
                end
            end
            if (k == 2) begin
                note_on = '0;
                if (extra_edge) sample_clk = 1'b1;
            end
            if (k == 3) sample_clk = 1'b0;
            @(negedge Clk);
            if (k >= 2 && k <= 5) begin
                dexp = '0;
                dexp[k-2] = e_done[k-2];
                chk($sformatf("incr_v%0d", k-2), incr, e_incr[k-2]);
                if (e_incr[k-2]) chk("incr_voice", incr_voice, k-2);
                chk($sformatf("note_done_v%0d", k-2), note_done, dexp);
            end else begin
                chk("incr_outside_scan", incr, 0);
                chk("note_done_outside_scan", note_done, 0);
            end
            chk($sformatf("frame_done_c%0d", k), frame_done, (k == 6));
        end
        if (extra_edge) m_over = 1;
        check_voices("frame");
        tick();
    endtask

    initial begin
        int t1_addr[4] = '{0, 2, 4, 4};
        Reset = 1'b1; init = 1'b0; sample_clk = 1'b0;
        note_on = '0; note_len = '0; note_step = '0; note_gate = '0;
        model_reset();
        tick(); tick();
        @(negedge Clk);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_incr", incr, 0);
        chk("rst_note_done", note_done, 0);
        tick();
        Reset = 1'b0;
        tick();
        check_voices("after_reset");

        // note_on staged before init; sample_clk edges ignored while waiting
        stage(0, 3, 2);
        sample_clk = 1'b1; tick(); sample_clk = 1'b0;
        idle_check(8);
        check_voices("pre_init");
        init = 1'b1; tick(); init = 1'b0;

        for (int f = 0; f < 4; f++) begin
            do_frame(-1, 0, 0, 0);
            chk("t1_voice0_addr", voice_addr[15:0], t1_addr[f]);
        end
        chk("t1_retired", voice_active[0], 0);

        // all voices, wrap on voice 3
        stage(0, 5, 1); stage(1, 5, 2); stage(2, 5, 3); stage(3, 5, 'hFFFF);
        for (int f = 0; f < 6; f++) begin
            do_frame(-1, 0, 0, 0);
            if (f == 1) chk("wrap_ffff", voice_addr[63:48], 'hFFFF);
            if (f == 2) chk("wrap_fffe", voice_addr[63:48], 'hFFFE);
        end

        // zero length behaves as one
        stage(2, 0, 7);
        do_frame(-1, 0, 0, 0);
        chk("len0_active", voice_active[2], 1);
        do_frame(-1, 0, 0, 0);
        chk("len0_retired", voice_active[2], 0);

        // overrun: second edge two cycles after the first
        stage(1, 4, 3);
        do_frame(-1, 0, 0, 1);
        chk("overrun_set", overrun, 1);
        idle_check(3);
        do_frame(-1, 0, 0, 0);
        init = 1'b1; tick(); init = 1'b0;
        m_over = 0;
        chk("overrun_cleared", overrun, 0);

        // retrigger mid-note, and note_on during LOAD deferred a frame
        for (int f = 0; f < 4; f++) do_frame(-1, 0, 0, 0);
        stage(1, 8, 5);
        do_frame(-1, 0, 0, 0); do_frame(-1, 0, 0, 0); do_frame(-1, 0, 0, 0);
        stage(1, 8, 5);
        do_frame(-1, 0, 0, 0);
        chk("retrig_addr0", voice_addr[31:16], 0);
        do_frame(2, 2, 9, 0);
        chk("load_cycle_note_deferred", voice_active[2], 0);
        do_frame(-1, 0, 0, 0);
        chk("load_cycle_note_applied", voice_active[2], 1);

        // gate held then dropped
        for (int f = 0; f < 12; f++) do_frame(-1, 0, 0, 0);
        note_gate = 4'b0001;
        stage(0, 2, 'h11);
        for (int f = 0; f < 6; f++) do_frame(-1, 0, 0, 0);
        note_gate = '0;
        for (int f = 0; f < 3; f++) do_frame(-1, 0, 0, 0);

        // reset in the middle of a scan
        stage(0, 4, 1);
        do_frame(-1, 0, 0, 0);
        sample_clk = 1'b1;
        tick();
        sample_clk = 1'b0;
        tick();
        Reset = 1'b1;
        @(negedge Clk);
        chk("midscan_rst_incr", incr, 0);
        chk("midscan_rst_note_done", note_done, 0);
        chk("midscan_rst_frame_done", frame_done, 0);
        tick();
        Reset = 1'b0;
        model_reset();
        idle_check(8);
        check_voices("after_midscan_reset");
        init = 1'b1; tick(); init = 1'b0;

        // random notes, lengths, steps and gates
        for (int f = 0; f < 40; f++) begin
            for (int v = 0; v < NV; v++)
                if ($urandom_range(3) == 0) stage(v, $urandom_range(6), $urandom);
            note_gate = NV'($urandom);
            if ($urandom_range(4) == 0)
                do_frame($urandom_range(NV-1), $urandom_range(6), $urandom, 0);
            else
                do_frame(-1, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
